// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M iterative multiply/divide unit.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [5:0] ITER_LAST = 6'd31;

endpackage

// File: rtl/rv32m_iter_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// acc layout: multiply {partial high, remaining multiplier bits};
//             divide   {partial remainder, dividend bits / quotient bits}.
module rv32m_iter_step
    import rv32m_pkg::*;
(
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     opb_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    // Compute both step flavours and pick one; the divide path keeps the
    // 33-bit shifted remainder so the compare never loses the top bit.
    always_comb begin
        mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + ({1'b0, opb_i} & {(XLEN+1){acc_i[0]}});
        div_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb_i});
        div_diff  = div_shift[XLEN-1:0] - opb_i;
        if (is_div_i) begin
            if (div_ge) begin
                acc_o = {div_diff, acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {div_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M execute unit: 32 iterations of shift-add / restoring divide
// on operand magnitudes, followed by a sign fix and a register-file write-back.
module rv32m_muldiv_unit
    import rv32m_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  op_a_i,
    input  logic [XLEN-1:0]  op_b_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [4:0]       wb_addr_o,
    output logic             wb_en_o
);

    state_e              state_q, state_d;
    logic [5:0]          cnt_q;
    logic [2:0]          f3_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     opb_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q;
    logic                fix_wait_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                div_zero, div_ovf, special, neg_in;
    logic [2*XLEN-1:0]   special_acc;
    logic [2*XLEN-1:0]   step_acc;
    logic [2*XLEN-1:0]   prod_fixed;
    logic [XLEN-1:0]     fix_result;

    assign accept = start_i && !flush_i && (state_q == ST_IDLE || state_q == ST_DONE);

    // Decode the incoming op: operand magnitudes, result sign and special cases.
    always_comb begin
        a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        sign_a   = a_signed && op_a_i[XLEN-1];
        sign_b   = b_signed && op_b_i[XLEN-1];
        abs_a    = sign_a ? -op_a_i : op_a_i;
        abs_b    = sign_b ? -op_b_i : op_b_i;
        // REM/REMU take the dividend's sign; everything else the XOR of both.
        neg_in   = (funct3_i[2] && funct3_i[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero = funct3_i[2] && (op_b_i == '0);
        div_ovf  = funct3_i[2] && !funct3_i[0] &&
                   (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        // Preload both remainder (high) and quotient (low) so FIX selects as usual.
        special_acc = div_zero ? {op_a_i, 32'hFFFF_FFFF} : {32'h0000_0000, 32'h8000_0000};
    end

    rv32m_iter_step u_step (
        .is_div_i (f3_q[2]),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc)
    );

    // Sign fix and result word selection applied in FIX.
    always_comb begin
        prod_fixed = neg_q ? -acc_q : acc_q;
        case (f3_q)
            F3_MUL:                     fix_result = prod_fixed[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fixed[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:            fix_result = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            default:                    fix_result = neg_q ? -acc_q[2*XLEN-1:XLEN]
                                                           : acc_q[2*XLEN-1:XLEN];
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition out of CALC/FIX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_FIX : ST_CALC;
            ST_CALC: begin
                if (flush_i)                 state_d = ST_IDLE;
                else if (cnt_q == ITER_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (flush_i)          state_d = ST_IDLE;
                else if (!fix_wait_q) state_d = ST_DONE;
            end
            default: state_d = accept ? (special ? ST_FIX : ST_CALC) : ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy_o  = (state_q == ST_CALC) || (state_q == ST_FIX);
        done_o  = (state_q == ST_DONE);
        wb_en_o = (state_q == ST_DONE) && (rd_q != 5'd0);
    end

    assign result_o  = result_q;
    assign wb_addr_o = rd_q;

    // Operand capture, iteration and result write. Special-case ops hold FIX
    // one extra cycle so they complete two edges after accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            fix_wait_q <= 1'b0;
            result_q   <= '0;
        end else if (accept) begin
            cnt_q      <= '0;
            f3_q       <= funct3_i;
            rd_q       <= rd_addr_i;
            opb_q      <= abs_b;
            acc_q      <= special ? special_acc : {{XLEN{1'b0}}, abs_a};
            neg_q      <= special ? 1'b0 : neg_in;
            fix_wait_q <= special;
        end else if (!flush_i) begin
            if (state_q == ST_CALC) begin
                acc_q <= step_acc;
                cnt_q <= cnt_q + 6'd1;
            end
            if (state_q == ST_FIX) begin
                fix_wait_q <= 1'b0;
                if (!fix_wait_q) result_q <= fix_result;
            end
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed ops push expectations,
// a negedge monitor pops and checks them whenever DONE is seen.
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        flush = 1'b0;
    logic        busy, done, wb_en;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] last_res = 32'd0;

    rv32m_muldiv_unit dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .funct3_i  (funct3),
        .op_a_i    (op_a),
        .op_b_i    (op_b),
        .rd_addr_i (rd_addr),
        .flush_i   (flush),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result),
        .wb_addr_o (wb_addr),
        .wb_en_o   (wb_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop one expectation per DONE pulse and compare everything.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got result %0h expected no DONE", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_wb_addr"}, wb_addr, e.rd);
                check({e.name, "_wb_en"}, wb_en, (e.rd != 5'd0));
                check({e.name, "_latency_cycle"}, cyc, e.due);
                last_res = e.res;
                $display("op %s done: result=%h rd=%0d wb_en=%0b cycle=%0d", e.name, result, wb_addr, wb_en, cyc);
            end
        end else if (wb_en) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_en_without_done: got 1 expected 0");
        end
    end

    // Present one op for one accept edge; operands are scrambled afterwards.
    task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int lat, input bit expect_done, input bit at_now);
        exp_t e;
        if (!at_now) @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_addr = rd;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
        if (expect_done) begin
            e.name = nm; e.res = exp; e.rd = rd; e.due = cyc + lat;
            sb_q.push_back(e);
        end
        check({nm, "_busy_after_accept"}, busy, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_done_negedge();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done_timeout: got 0 expected 1");
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 32'd0);
        check("reset_wb_addr", wb_addr, 5'd0);
        check("reset_wb_en", wb_en, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Multiply family.
        issue("MUL_7x6",      3'b000, 32'd7,          32'd6,          5'd5,  32'd42,         33, 1, 0); drain();
        issue("MULH_m1xm1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  33, 1, 0); drain();
        issue("MULHU_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33, 1, 0); drain();
        issue("MULHSU_m1x2",  3'b010, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  33, 1, 0); drain();
        // Divide family.
        issue("DIV_m7d2",     3'b100, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  33, 1, 0); drain();
        issue("REM_m7d2",     3'b110, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33, 1, 0); drain();
        issue("DIVU_100d7",   3'b101, 32'd100,        32'd7,          5'd7,  32'd14,         33, 1, 0); drain();
        issue("REMU_100d7",   3'b111, 32'd100,        32'd7,          5'd8,  32'd2,          33, 1, 0); drain();
        // Special cases resolved at accept.
        issue("DIVU_5d0",     3'b101, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  2,  1, 0); drain();
        issue("REM_5d0",      3'b110, 32'd5,          32'd0,          5'd10, 32'd5,          2,  1, 0); drain();
        issue("DIV_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  2,  1, 0); drain();
        issue("REM_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          2,  1, 0); drain();
        // rd = x0: DONE pulses, no write enable.
        issue("MUL_rd0",      3'b000, 32'd3,          32'd4,          5'd0,  32'd12,         33, 1, 0); drain();

        // START while busy is ignored.
        issue("DIVU_busy",    3'b101, 32'd50,         32'd5,          5'd13, 32'd10,         33, 1, 0);
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; rd_addr = 5'd14;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Back-to-back: second op accepted on the edge ending DONE.
        issue("DIVU_b2b_1",   3'b101, 32'd1000,       32'd10,         5'd15, 32'd100,        33, 1, 0);
        wait_done_negedge();
        issue("MUL_b2b_2",    3'b000, 32'd123,        32'd1000,       5'd16, 32'd123000,     33, 1, 1);
        drain();

        // FLUSH at iteration 10: no DONE, RESULT unchanged.
        issue("MUL_flushed",  3'b000, 32'd9,          32'd9,          5'd17, 32'd0,          33, 0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_result_kept", result, last_res);
        repeat (40) @(negedge clk);
        check("flush_result_after_wait", result, last_res);

        // FLUSH with START in IDLE drops the START.
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_addr = 5'd18;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_dropped", busy, 1'b0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-CALC.
        issue("MUL_reset",    3'b000, 32'd5,          32'd5,          5'd19, 32'd0,          33, 0, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        check("midreset_result", result, 32'd0);
        check("midreset_wb_addr", wb_addr, 5'd0);
        check("midreset_wb_en", wb_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_idle", busy, 1'b0);

        issue("MUL_recover",  3'b000, 32'd7,          32'd6,          5'd20, 32'd42,         33, 1, 0); drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
